// File: rtl/psum_accum_stage.sv
// psum_accum_stage: read-modify-write psum accumulation in front of the PE scratchpad.
// Ports: prod_* valid/ready product in; spad_* scratchpad rd/wr; psum_* completed psum out;
//   done_cnt counts delivered psums. Define PSUM_SAT_EN for a saturating add and the sat_flag port.
module psum_accum_stage #(
  parameter int PROD_WIDTH = 16,
  parameter int PSUM_WIDTH = 24,
  parameter int DEPTH      = 96,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic [ADDR_WIDTH-1:0] prod_addr,
  input  logic                  prod_first,
  input  logic                  prod_last,
  output logic                  spad_chip_en,
  output logic                  spad_ren,
  output logic [ADDR_WIDTH-1:0] spad_raddr,
  output logic                  spad_wen,
  output logic [ADDR_WIDTH-1:0] spad_waddr,
  output logic [PSUM_WIDTH-1:0] spad_din,
  input  logic [PSUM_WIDTH-1:0] spad_dout,
`ifdef PSUM_SAT_EN
  output logic                  sat_flag,
`endif
  output logic                  psum_valid,
  input  logic                  psum_ready,
  output logic [PSUM_WIDTH-1:0] psum_data,
  output logic [ADDR_WIDTH-1:0] psum_addr,
  output logic [15:0]           done_cnt
);

  logic                  rdy_q;
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [PROD_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_first_q, s1_first_d;
  logic                  s1_last_q, s1_last_d;
  logic                  s1_fwd_q, s1_fwd_d;
  logic [PSUM_WIDTH-1:0] fwd_sum_q, fwd_sum_d;
  logic                  pv_q, pv_d;
  logic [PSUM_WIDTH-1:0] pdata_q, pdata_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [15:0]           cnt_q, cnt_d;

  logic                  stall, accept, wr, load, hs;
  logic [PSUM_WIDTH-1:0] operand, prod_ext, sum;

  assign stall  = s1_valid_q & s1_last_q & pv_q & ~psum_ready;
  assign prod_ready = rdy_q & ~stall;
  assign accept = prod_valid & prod_ready;
  assign wr     = s1_valid_q & ~stall;
  assign load   = wr & s1_last_q;
  assign hs     = pv_q & psum_ready;

  assign prod_ext = {{(PSUM_WIDTH-PROD_WIDTH){s1_data_q[PROD_WIDTH-1]}}, s1_data_q};

  always_comb begin
    operand = spad_dout;
    if (s1_first_q)    operand = '0;
    else if (s1_fwd_q) operand = fwd_sum_q;
  end

`ifdef PSUM_SAT_EN
  logic [PSUM_WIDTH:0] wide;
  logic                ovf;
  assign wide = {operand[PSUM_WIDTH-1], operand} + {prod_ext[PSUM_WIDTH-1], prod_ext};
  // sign of the extra bit picks the rail when the two top bits disagree
  assign ovf  = wide[PSUM_WIDTH] ^ wide[PSUM_WIDTH-1];
  always_comb begin
    sum = wide[PSUM_WIDTH-1:0];
    if (ovf) sum = wide[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                    : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  end
  assign sat_flag = wr & ovf;
`else
  assign sum = operand + prod_ext;
`endif

  assign spad_ren     = accept;
  assign spad_raddr   = accept ? prod_addr : '0;
  assign spad_wen     = wr;
  assign spad_waddr   = wr ? s1_addr_q : '0;
  assign spad_din     = wr ? sum : '0;
  assign spad_chip_en = spad_ren | spad_wen;

  assign psum_valid = pv_q;
  assign psum_data  = pdata_q;
  assign psum_addr  = paddr_q;
  assign done_cnt   = cnt_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_fwd_d   = s1_fwd_q;
    fwd_sum_d  = fwd_sum_q;
    pv_d       = pv_q;
    pdata_d    = pdata_q;
    paddr_d    = paddr_q;
    cnt_d      = cnt_q;
    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_addr_d  = prod_addr;
        s1_data_d  = prod_data;
        s1_first_d = prod_first;
        s1_last_d  = prod_last;
        // the beat now in S1 writes this cycle; its sum lands in fwd_sum
        s1_fwd_d   = s1_valid_q & (s1_addr_q == prod_addr);
      end
    end
    if (wr) fwd_sum_d = sum;
    if (hs) begin
      pv_d  = 1'b0;
      cnt_d = cnt_q + 16'd1;
    end
    if (load) begin
      pv_d    = 1'b1;
      pdata_d = sum;
      paddr_d = s1_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_fwd_q   <= 1'b0;
      fwd_sum_q  <= '0;
      pv_q       <= 1'b0;
      pdata_q    <= '0;
      paddr_q    <= '0;
      cnt_q      <= '0;
    end else begin
      rdy_q      <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_fwd_q   <= s1_fwd_d;
      fwd_sum_q  <= fwd_sum_d;
      pv_q       <= pv_d;
      pdata_q    <= pdata_d;
      paddr_q    <= paddr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_psum_accum_stage.sv
// tb_psum_accum_stage: scoreboard bench for psum_accum_stage.
// Behavioural scratchpad model; monitor pops expected writes and psums.
module tb_psum_accum_stage;

  localparam int AW = 7;
  localparam int PW = 24;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prod_valid;
  logic          prod_ready;
  logic [15:0]   prod_data;
  logic [AW-1:0] prod_addr;
  logic          prod_first;
  logic          prod_last;
  logic          spad_chip_en;
  logic          spad_ren;
  logic [AW-1:0] spad_raddr;
  logic          spad_wen;
  logic [AW-1:0] spad_waddr;
  logic [PW-1:0] spad_din;
  logic [PW-1:0] spad_dout;
  logic          psum_valid;
  logic          psum_ready;
  logic [PW-1:0] psum_data;
  logic [AW-1:0] psum_addr;
  logic [15:0]   done_cnt;
`ifdef PSUM_SAT_EN
  logic          sat_flag;
`endif

  logic [PW-1:0] mem [0:95];

  exp_t wq[$];
  exp_t pq[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  psum_accum_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .prod_data(prod_data),
    .prod_addr(prod_addr),
    .prod_first(prod_first),
    .prod_last(prod_last),
    .spad_chip_en(spad_chip_en),
    .spad_ren(spad_ren),
    .spad_raddr(spad_raddr),
    .spad_wen(spad_wen),
    .spad_waddr(spad_waddr),
    .spad_din(spad_din),
    .spad_dout(spad_dout),
`ifdef PSUM_SAT_EN
    .sat_flag(sat_flag),
`endif
    .psum_valid(psum_valid),
    .psum_ready(psum_ready),
    .psum_data(psum_data),
    .psum_addr(psum_addr),
    .done_cnt(done_cnt)
  );

  always @(posedge clk) begin
    if (spad_ren) spad_dout <= mem[spad_raddr];
    if (spad_wen) mem[spad_waddr] <= spad_din;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && spad_wen) begin
      if (wq.size() == 0) chk("unexpected_wen", 1, 0);
      else begin
        e = wq.pop_front();
        chk("wr_addr", int'(spad_waddr), e.addr);
        chk("wr_data", int'(spad_din), e.data);
      end
    end
    if (rst_n && psum_valid && psum_ready) begin
      if (pq.size() == 0) chk("unexpected_psum", 1, 0);
      else begin
        e = pq.pop_front();
        chk("psum_addr", int'(psum_addr), e.addr);
        chk("psum_data", int'(psum_data), e.data);
      end
    end
  end

  task automatic ew(input int a, input int d);
    wq.push_back('{addr: a, data: d});
  endtask

  task automatic ep(input int a, input int d);
    pq.push_back('{addr: a, data: d});
  endtask

  task automatic send(input int a, input int d, input bit f, input bit l);
    int t;
    t = 0;
    prod_valid = 1'b1;
    prod_addr  = AW'(a);
    prod_data  = 16'(d);
    prod_first = f;
    prod_last  = l;
    @(negedge clk);
    while (!prod_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!prod_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    prod_first = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    prod_valid = 1'b0;
    prod_data = '0;
    prod_addr = '0;
    prod_first = 1'b0;
    prod_last = 1'b0;
    psum_ready = 1'b1;
    for (int i = 0; i < 96; i++) mem[i] = '0;

    @(negedge clk);
    chk("rst_prod_ready", int'(prod_ready), 0);
    chk("rst_chip_en", int'(spad_chip_en), 0);
    chk("rst_psum_valid", int'(psum_valid), 0);
    chk("rst_done_cnt", int'(done_cnt), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1);

    // 1: back-to-back to addr 4 via forwarding
    ew(4, 5); ew(4, 2); ew(4, 9); ep(4, 9);
    send(4, 5, 1, 0);
    send(4, -3, 0, 0);
    send(4, 7, 0, 1);
    cyc(3);
    chk("t1_done_cnt", int'(done_cnt), 1);

    // 2: interleaved addresses, no forwarding
    ew(1, 10); ew(2, 20); ew(1, 11); ew(2, 21);
    send(1, 10, 1, 0);
    send(2, 20, 1, 0);
    send(1, 1, 0, 0);
    send(2, 1, 0, 0);
    cyc(3);

    // 3: downstream stall
    ew(0, 5); ew(1, 6); ep(0, 5); ep(1, 6);
    psum_ready = 1'b0;
    send(0, 5, 1, 1);
    send(1, 6, 1, 1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_prod_ready", int'(prod_ready), 0);
      chk("stall_ren", int'(spad_ren), 0);
      chk("stall_wen", int'(spad_wen), 0);
      chk("stall_psum_valid", int'(psum_valid), 1);
    end
    @(posedge clk);
    #1 psum_ready = 1'b1;
    cyc(3);
    chk("t3_done_cnt", int'(done_cnt), 3);

    // 4: overflow at addr 7
    mem[7] = 24'h7FFFFF;
`ifdef PSUM_SAT_EN
    ew(7, 'h7FFFFF); ep(7, 'h7FFFFF);
`else
    ew(7, 'h800000); ep(7, 'h800000);
`endif
    send(7, 1, 0, 1);
`ifdef PSUM_SAT_EN
    @(negedge clk);
    chk("sat_flag", int'(sat_flag), 1);
`endif
    cyc(3);
    chk("t4_done_cnt", int'(done_cnt), 4);

    // 5: reset right after accepting a last beat
    send(3, 50, 1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_wen", int'(spad_wen), 0);
    chk("midrst_psum_valid", int'(psum_valid), 0);
    chk("midrst_done_cnt", int'(done_cnt), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_psum_valid", int'(psum_valid), 0);
    chk("post_rst_wen", int'(spad_wen), 0);
    cyc(1);
    chk("post_rst_prod_ready", int'(prod_ready), 1);
    chk("post_rst_done_cnt", int'(done_cnt), 0);

    // 6: top address
    ew(95, 100); ew(95, 200); ew(95, 300); ep(95, 300);
    send(95, 100, 1, 0);
    send(95, 100, 0, 0);
    send(95, 100, 0, 1);
    cyc(3);
    chk("t6_done_cnt", int'(done_cnt), 1);

    t = 0;
    while ((wq.size() != 0 || pq.size() != 0) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("wq_drained", wq.size(), 0);
    chk("pq_drained", pq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
